// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer for an external combinational ALU.
//
// Accepts one command at a time and holds its operands and select on the ALU
// inputs for SETTLE_CYCLES clocks. It then captures the ALU result, presents
// it on a valid/ready response channel and returns to idle once the response
// has been consumed. An 8-bit accumulator keeps the low byte of the last good
// result, so a command can use it as operand A.
//
// Optional feature (macro ALU_SEQ_OPCHECK_EN, undefined by default):
//   Ops 4'b0010 and 4'b0111 are rejected, and so is 4'b0011 with operand B = 0.
//   A rejected command leaves the ALU inputs and the accumulator untouched.
//   It goes straight to the response state with rsp_err = 1 and rsp_data = 0.
//   Without the macro every opcode is issued and rsp_err stays 0.
//
// Parameters:
//   SETTLE_CYCLES  clocks the operands are held before sampling (1..15)
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    block can accept a command (high only while idle)
//   cmd_op       ALU select code to issue
//   cmd_a        operand A
//   cmd_b        operand B
//   cmd_use_acc  take operand A from the accumulator instead of cmd_a
//   alu_a        operand A to the ALU
//   alu_b        operand B to the ALU
//   alu_sel      select to the ALU
//   alu_result   ALU result (9 bits, bit 8 is carry/borrow)
//   rsp_valid    response present
//   rsp_ready    consumer accepts the response
//   rsp_data     captured ALU result (0 on a rejected command)
//   rsp_err      command was rejected
module alu_cmd_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [8:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  // Counter value at which the result is sampled.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] acc_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_sel_q;
  logic       rsp_valid_q;
  logic [8:0] rsp_data_q;
  logic       rsp_err_q;
  logic       cmd_illegal;

`ifdef ALU_SEQ_OPCHECK_EN
  // Reserved ops, and op 0011 with a zero divisor-like operand B.
  assign cmd_illegal = (cmd_op == 4'b0010) || (cmd_op == 4'b0111) ||
                       ((cmd_op == 4'b0011) && (cmd_b == 8'd0));
`else
  assign cmd_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      acc_q       <= 8'd0;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_sel_q   <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 9'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_illegal) begin
              // Rejected: ALU inputs keep the previous command's values.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 9'd0;
              state_q     <= StResp;
            end else begin
              alu_a_q   <= cmd_use_acc ? acc_q : cmd_a;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_op;
              cnt_q     <= 4'd0;
              state_q   <= StSettle;
            end
          end
        end
        StSettle: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SettleLast) begin
            rsp_data_q  <= alu_result;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            // Carry bit is reported in the response but not accumulated.
            acc_q       <= alu_result[7:0];
            state_q     <= StResp;
          end
        end
        StResp: begin
          // cmd_ready is low here, so no command can slip in on this edge.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
